// File: rtl/pe_fadd_arbiter.sv
// rtl/pe_fadd_arbiter.sv - round-robin arbiter sharing one single-precision adder
// Includes add_f32: combinational IEEE-754 add, denormals flushed to zero, round-to-nearest-even.

module add_f32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    logic               s_big, s_sml;
    logic [7:0]         e_big, e_sml, d;
    logic [23:0]        m_big, m_sml;
    logic [26:0]        ext, al, mask, n;
    logic               sticky, up;
    logic [27:0]        s;
    logic [4:0]         lz;
    logic signed [9:0]  e_n;
    logic [24:0]        m_r;
    logic               nan_a, nan_b, inf_a, inf_b;

    always_comb begin
        if (a_i[30:0] >= b_i[30:0]) begin
            {s_big, e_big} = {a_i[31], a_i[30:23]};
            {s_sml, e_sml} = {b_i[31], b_i[30:23]};
            m_big = {1'b1, a_i[22:0]};
            m_sml = {1'b1, b_i[22:0]};
        end else begin
            {s_big, e_big} = {b_i[31], b_i[30:23]};
            {s_sml, e_sml} = {a_i[31], a_i[30:23]};
            m_big = {1'b1, b_i[22:0]};
            m_sml = {1'b1, a_i[22:0]};
        end
        d   = e_big - e_sml;
        ext = {m_sml, 3'b000};
        // Three extra bits give guard/round; bits shifted past them fold into the sticky LSB.
        if (d >= 8'd27) begin
            mask   = '0;
            al     = '0;
            sticky = 1'b1;
        end else begin
            mask   = (27'd1 << d) - 27'd1;
            al     = ext >> d;
            sticky = |(ext & mask);
        end
        al[0] = al[0] | sticky;
        if (s_big == s_sml)
            s = {1'b0, m_big, 3'b000} + {1'b0, al};
        else
            s = {1'b0, m_big, 3'b000} - {1'b0, al};
        lz = '0;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end
        if (s[27]) begin
            n   = s[27:1] | {26'b0, s[0]};
            e_n = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            n   = s[26:0] << lz;
            e_n = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
        end
        up  = n[2] & (n[1] | n[0] | n[3]);
        m_r = {1'b0, n[26:3]} + {24'b0, up};
        if (m_r[24]) begin
            m_r = m_r >> 1;
            e_n = e_n + 10'sd1;
        end
        sum_o = {s_big, e_n[7:0], m_r[22:0]};
        if (s == '0)
            sum_o = 32'h0000_0000;
        else if (e_n <= 10'sd0)
            sum_o = {s_big, 31'b0};
        else if (e_n >= 10'sd255)
            sum_o = {s_big, 8'hFF, 23'b0};
        if (a_i[30:23] == 8'h00 && b_i[30:23] == 8'h00)
            sum_o = 32'h0000_0000;
        else if (a_i[30:23] == 8'h00)
            sum_o = b_i;
        else if (b_i[30:23] == 8'h00)
            sum_o = a_i;
        inf_a = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
        inf_b = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);
        nan_a = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
        nan_b = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
        if (nan_a || nan_b || (inf_a && inf_b && (a_i[31] != b_i[31])))
            sum_o = 32'h7FC0_0000;
        else if (inf_a)
            sum_o = a_i;
        else if (inf_b)
            sum_o = b_i;
    end
endmodule

module pe_fadd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic [IDW-1:0]           rsp_id
);
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   grant;
    logic             found, can_load, hs;
    logic [WIDTH-1:0] op_a, op_b, add_sum;

    always_comb begin : grant_search
        int idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    // Gating with rst_n keeps req_ready low throughout reset even though it is combinational.
    assign can_load  = !rsp_valid_q || rsp_ready;
    assign hs        = found && can_load && rst_n;
    assign req_ready = hs ? (NUM_REQ'(1) << grant) : '0;

    assign op_a = req_a[grant*WIDTH +: WIDTH];
    assign op_b = req_b[grant*WIDTH +: WIDTH];

    add_f32 u_add (
        .a_i   (op_a),
        .b_i   (op_b),
        .sum_o (add_sum)
    );

    always_comb begin
        ptr_d       = ptr_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_valid_d = rsp_valid_q;
        if (hs) begin
            rsp_sum_d   = add_sum;
            rsp_id_d    = grant;
            rsp_valid_d = 1'b1;
            ptr_d       = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_pe_fadd_arbiter.sv
// tb/tb_pe_fadd_arbiter.sv - vector table plus scoreboard bench for pe_fadd_arbiter
module tb_pe_fadd_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_sum;
    logic [1:0]      rsp_id;

    pe_fadd_arbiter #(.NUM_REQ(N), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] sum;
    } sb_t;

    vec_t        vecs[11];
    sb_t         sb[$];
    int          seen[$];
    logic [31:0] exp_sum[N];
    int          m_ptr = 0;
    bit          m_valid = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] s);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        exp_sum[id]        = s;
    endtask

    // Reference model: round-robin grant and result-register occupancy.
    always @(negedge clk) begin : mon
        int           g;
        bit           found;
        bit           hs;
        logic [N-1:0] er;
        if (!rst_n) begin
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_sum", rsp_sum, 32'd0);
            chk("rst_rsp_id", 32'(rsp_id), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            sb.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
        end else begin
            if (m_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_empty: got result %08h expected none", rsp_sum);
                end else begin
                    chk("sb_rsp_sum", rsp_sum, sb[0].sum);
                    chk("sb_rsp_id", 32'(rsp_id), 32'(sb[0].id));
                    if (rsp_ready) begin
                        seen.push_back(int'(rsp_id));
                        void'(sb.pop_front());
                    end
                end
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    g     = (m_ptr + k) % N;
                end
            end
            hs = found && (!m_valid || rsp_ready);
            er = '0;
            if (hs) er[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            if (hs) begin
                sb.push_back('{g, exp_sum[g]});
                m_ptr = (g + 1) % N;
            end
            m_valid = hs ? 1'b1 : (rsp_ready ? 1'b0 : m_valid);
        end
    end

    initial begin
        vecs[0]  = '{0, 32'h3FC00000, 32'h3E800000, 32'h3FE00000};
        vecs[1]  = '{1, 32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[2]  = '{2, 32'h43FA0F5C, 32'hC3FA0F5C, 32'h00000000};
        vecs[3]  = '{3, 32'h41A66666, 32'h3F99999A, 32'h41B00000};
        vecs[4]  = '{0, 32'h3FC00000, 32'hC0200000, 32'hBF800000};
        vecs[5]  = '{1, 32'h41200000, 32'hC0A00000, 32'h40A00000};
        vecs[6]  = '{2, 32'h00000001, 32'h3F800000, 32'h3F800000};
        vecs[7]  = '{3, 32'h3F800000, 32'h33800000, 32'h3F800000};
        vecs[8]  = '{0, 32'h3F800000, 32'h34000000, 32'h3F800001};
        vecs[9]  = '{1, 32'h7F000000, 32'h7F000000, 32'h7F800000};
        vecs[10] = '{2, 32'hBF800000, 32'hBF800000, 32'hC0000000};

        for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, 32'h3F800000, 32'h40000000);

        // Reset with every requester asserting valid.
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        step(2);
        req_valid = '0;
        rst_n     = 1'b1;
        step(1);

        foreach (vecs[i]) begin
            set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum);
            req_valid = '0;
            req_valid[vecs[i].id] = 1'b1;
            step(1);
            req_valid = '0;
            chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("vec_rsp_sum", rsp_sum, vecs[i].sum);
            chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[i].id));
            step(1);
            chk("vec_drained", 32'(rsp_valid), 32'd0);
        end

        // Round-robin from ptr=0 with all requesters continuously valid.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        set_req(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
        set_req(1, 32'h41200000, 32'hC0A00000, 32'h40A00000);
        set_req(2, 32'h3FC00000, 32'h3E800000, 32'h3FE00000);
        set_req(3, 32'h41A66666, 32'h3F99999A, 32'h41B00000);
        seen.delete();
        req_valid = 4'hF;
        step(5);
        req_valid = '0;
        step(1);
        chk("rr_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk("rr_id", 32'(seen[i]), 32'(i % N));

        // Backpressure: result held while rsp_ready is low.
        set_req(0, 32'h3FC00000, 32'hC0200000, 32'hBF800000);
        set_req(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        step(1);
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_sum", rsp_sum, 32'hBF800000);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0010);
        step(1);
        req_valid = '0;
        chk("bp_next_sum", rsp_sum, 32'h40000000);
        chk("bp_next_id", 32'(rsp_id), 32'd1);
        step(1);

        // Skip idle requesters with ptr=2: valid on 1 and 3.
        set_req(1, 32'h3F800000, 32'h40000000, 32'h40400000);
        set_req(3, 32'h41A66666, 32'h3F99999A, 32'h41B00000);
        seen.delete();
        req_valid = 4'b1010;
        #1;
        chk("skip_first_ready", 32'(req_ready), 32'b1000);
        step(1);
        req_valid = 4'b0010;
        #1;
        chk("skip_second_ready", 32'(req_ready), 32'b0010);
        step(1);
        req_valid = '0;
        step(1);
        chk("skip_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("skip_id0", 32'(seen[0]), 32'd3);
            chk("skip_id1", 32'(seen[1]), 32'd1);
        end

        // Asynchronous reset between edges with a result pending.
        set_req(2, 32'h3F800000, 32'h3F800000, 32'h40000000);
        set_req(3, 32'h3FC00000, 32'h3E800000, 32'h3FE00000);
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        step(1);
        chk("mid_pending", 32'(rsp_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_sum", rsp_sum, 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b1100;
        step(1);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        seen.delete();
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b0100);
        step(2);
        req_valid = '0;
        step(2);
        chk("post_rst_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("post_rst_id0", 32'(seen[0]), 32'd2);
            chk("post_rst_id1", 32'(seen[1]), 32'd3);
        end

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
